// File: rtl/errors_reporter.sv
// rtl/errors_reporter.sv - drains a sticky error vector as one index record per newly set bit
// Optional ERRORS_REPORTER_TIMESTAMP_EN adds a per-burst snapshot timestamp output.
package errors_reporter_pkg;
  typedef struct packed {
    logic clk;
    logic arst;
  } gnet_t;
endpackage

module errors_reporter
  import errors_reporter_pkg::*;
#(
  parameter int BITS = 8,
  parameter bit SKIP_RESET_RESYNC = 1'b0,
  localparam int IDX_W = (BITS > 1) ? $clog2(BITS) : 1
) (
  input  gnet_t             gnet,
  input  logic [BITS-1:0]   i_errors,
  input  logic              i_rearm,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [IDX_W-1:0]  o_index,
  output logic              o_last,
  output logic              o_busy,
  output logic [15:0]       o_count
`ifdef ERRORS_REPORTER_TIMESTAMP_EN
  ,
  output logic [31:0]       o_timestamp
`endif
);

  typedef enum logic {S_IDLE, S_SEND} state_t;

  logic clk;
  logic arst_n;
  logic rst_n;
  assign clk    = gnet.clk;
  assign arst_n = gnet.arst;

  // Assertion stays asynchronous; only the release edge is retimed to clk.
  if (SKIP_RESET_RESYNC) begin : g_no_resync
    assign rst_n = arst_n;
  end else begin : g_resync
    logic [1:0] sync_q;
    always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) sync_q <= 2'b00;
      else         sync_q <= {sync_q[0], 1'b1};
    end
    assign rst_n = sync_q[1];
  end

  function automatic logic [IDX_W-1:0] lowest_idx(input logic [BITS-1:0] v);
    lowest_idx = '0;
    for (int i = BITS - 1; i >= 0; i--) begin
      if (v[i]) lowest_idx = IDX_W'(i);
    end
  endfunction

  state_t          state_q, state_d;
  logic [BITS-1:0] pending_q, pending_d;
  logic [BITS-1:0] reported_q, reported_d;
  logic            rearm_q, rearm_d;
  logic [15:0]     count_q, count_d;
  logic [IDX_W-1:0] index_q;
  logic            last_q;
  logic            valid_q;
  logic [BITS-1:0] new_bits;
  logic [BITS-1:0] lowest_oh;
  logic            snapshot;

  assign new_bits  = i_errors & ~reported_q;
  assign lowest_oh = pending_q & (~pending_q + BITS'(1));

  always_comb begin
    state_d    = state_q;
    pending_d  = pending_q;
    reported_d = reported_q;
    rearm_d    = rearm_q;
    count_d    = count_q;
    snapshot   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (rearm_q || i_rearm) begin
          reported_d = '0;
          rearm_d    = 1'b0;
        end else if (|new_bits) begin
          pending_d = new_bits;
          state_d   = S_SEND;
          snapshot  = 1'b1;
        end
      end
      default: begin
        if (i_rearm) rearm_d = 1'b1;
        if (i_ready) begin
          pending_d  = pending_q & ~lowest_oh;
          reported_d = reported_q | lowest_oh;
          if (count_q != 16'hFFFF) count_d = count_q + 16'd1;
          if (last_q) state_d = S_IDLE;
        end
      end
    endcase
  end

  // Record fields are registered from next-state pending so they are stable under backpressure.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      pending_q  <= '0;
      reported_q <= '0;
      rearm_q    <= 1'b0;
      count_q    <= '0;
      index_q    <= '0;
      last_q     <= 1'b0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      pending_q  <= pending_d;
      reported_q <= reported_d;
      rearm_q    <= rearm_d;
      count_q    <= count_d;
      index_q    <= lowest_idx(pending_d);
      last_q     <= (pending_d != '0) && ((pending_d & (pending_d - BITS'(1))) == '0);
      valid_q    <= (state_d == S_SEND);
    end
  end

`ifdef ERRORS_REPORTER_TIMESTAMP_EN
  logic [31:0] cycle_q;
  logic [31:0] stamp_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle_q <= '0;
      stamp_q <= '0;
    end else begin
      cycle_q <= cycle_q + 32'd1;
      if (snapshot) stamp_q <= cycle_q;
    end
  end
  assign o_timestamp = stamp_q;
`endif

  assign o_valid = valid_q;
  assign o_index = index_q;
  assign o_last  = last_q;
  assign o_busy  = (state_q != S_IDLE);
  assign o_count = count_q;

endmodule

// File: tb/tb_errors_reporter.sv
// tb/tb_errors_reporter.sv - directed self-checking bench for errors_reporter
module tb_errors_reporter;
  import errors_reporter_pkg::*;

  logic        clk = 1'b0;
  logic        arst_n = 1'b0;
  gnet_t       gnet;
  logic [7:0]  i_errors = 8'h00;
  logic        i_rearm = 1'b0;
  logic        i_ready = 1'b0;
  logic        o_valid;
  logic [2:0]  o_index;
  logic        o_last;
  logic        o_busy;
  logic [15:0] o_count;
`ifdef ERRORS_REPORTER_TIMESTAMP_EN
  logic [31:0] o_timestamp;
`endif

  int checks = 0;
  int failures = 0;

  assign gnet.clk  = clk;
  assign gnet.arst = arst_n;

  always #5 clk = ~clk;

  errors_reporter #(.BITS(8), .SKIP_RESET_RESYNC(1'b0)) dut (
    .gnet(gnet), .i_errors(i_errors), .i_rearm(i_rearm), .o_valid(o_valid),
    .i_ready(i_ready), .o_index(o_index), .o_last(o_last), .o_busy(o_busy),
`ifdef ERRORS_REPORTER_TIMESTAMP_EN
    .o_timestamp(o_timestamp),
`endif
    .o_count(o_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Record check: valid, index, last presented after the current edge.
  task automatic chk_rec(input string tag, input logic v, input logic [2:0] idx, input logic l);
    chk({tag, ".valid"}, {31'd0, o_valid}, {31'd0, v});
    if (v) begin
      chk({tag, ".index"}, {29'd0, o_index}, {29'd0, idx});
      chk({tag, ".last"}, {31'd0, o_last}, {31'd0, l});
    end
  endtask

  task automatic do_reset();
    arst_n = 1'b0; i_errors = 8'h00; i_rearm = 1'b0; i_ready = 1'b0;
    tick(); tick();
    arst_n = 1'b1;
    tick(); tick(); tick();
  endtask

  initial begin
    // Reset values
    tick();
    chk("rst.valid", {31'd0, o_valid}, 32'd0);
    chk("rst.index", {29'd0, o_index}, 32'd0);
    chk("rst.last",  {31'd0, o_last},  32'd0);
    chk("rst.busy",  {31'd0, o_busy},  32'd0);
    chk("rst.count", {16'd0, o_count}, 32'd0);
    do_reset();

    // Quiet vector for 20 cycles
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("quiet.valid", {31'd0, o_valid}, 32'd0);
    end
    chk("quiet.count", {16'd0, o_count}, 32'd0);
    chk("quiet.busy",  {31'd0, o_busy},  32'd0);

    // Three bits in one cycle, ascending order, last on highest
    i_errors = 8'h29; i_ready = 1'b1;
    tick(); chk_rec("b29.r0", 1'b1, 3'd0, 1'b0);
    chk("b29.busy", {31'd0, o_busy}, 32'd1);
    tick(); chk_rec("b29.r1", 1'b1, 3'd3, 1'b0);
    tick(); chk_rec("b29.r2", 1'b1, 3'd5, 1'b1);
    tick(); chk_rec("b29.end", 1'b0, 3'd0, 1'b0);
    chk("b29.count", {16'd0, o_count}, 32'd3);
    tick(); chk_rec("b29.noreport", 1'b0, 3'd0, 1'b0);

    // Backpressure: record holds stable over 5 stalled cycles
    do_reset();
    i_errors = 8'h02; i_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick(); chk_rec("stall", 1'b1, 3'd1, 1'b1);
    end
    i_ready = 1'b1;
    tick(); chk_rec("stall.end", 1'b0, 3'd0, 1'b0);
    chk("stall.count", {16'd0, o_count}, 32'd1);

    // Bit rising during SEND lands in a later burst
    do_reset();
    i_errors = 8'h01; i_ready = 1'b1;
    tick(); chk_rec("late.r0", 1'b1, 3'd0, 1'b1);
    i_errors = 8'h81;
    tick(); chk_rec("late.gap", 1'b0, 3'd0, 1'b0);
    tick(); chk_rec("late.r1", 1'b1, 3'd7, 1'b1);
    tick(); chk_rec("late.end", 1'b0, 3'd0, 1'b0);
    chk("late.count", {16'd0, o_count}, 32'd2);

    // Re-arm in IDLE: bits held upstream are reported again
    do_reset();
    i_errors = 8'h05; i_ready = 1'b1;
    tick(); chk_rec("ri.r0", 1'b1, 3'd0, 1'b0);
    tick(); chk_rec("ri.r1", 1'b1, 3'd2, 1'b1);
    tick(); chk_rec("ri.end", 1'b0, 3'd0, 1'b0);
    tick(); chk_rec("ri.idle", 1'b0, 3'd0, 1'b0);
    i_rearm = 1'b1;
    tick(); chk_rec("ri.rearm", 1'b0, 3'd0, 1'b0);
    i_rearm = 1'b0;
    tick(); chk_rec("ri.r2", 1'b1, 3'd0, 1'b0);
    tick(); chk_rec("ri.r3", 1'b1, 3'd2, 1'b1);
    tick(); chk_rec("ri.end2", 1'b0, 3'd0, 1'b0);
    chk("ri.count", {16'd0, o_count}, 32'd4);

    // Re-arm coinciding with the last handshake is deferred to IDLE
    do_reset();
    i_errors = 8'h05; i_ready = 1'b1;
    tick(); chk_rec("rs.r0", 1'b1, 3'd0, 1'b0);
    tick(); chk_rec("rs.r1", 1'b1, 3'd2, 1'b1);
    i_rearm = 1'b1;
    tick(); chk_rec("rs.end", 1'b0, 3'd0, 1'b0);
    i_rearm = 1'b0;
    chk("rs.count2", {16'd0, o_count}, 32'd2);
    tick(); chk_rec("rs.apply", 1'b0, 3'd0, 1'b0);
    tick(); chk_rec("rs.r2", 1'b1, 3'd0, 1'b0);
    tick(); chk_rec("rs.r3", 1'b1, 3'd2, 1'b1);
    tick(); chk_rec("rs.end2", 1'b0, 3'd0, 1'b0);
    chk("rs.count", {16'd0, o_count}, 32'd4);

    // Asynchronous reset mid-burst discards it; burst reappears after release
    do_reset();
    i_errors = 8'h07; i_ready = 1'b1;
    tick(); chk_rec("ar.r0", 1'b1, 3'd0, 1'b0);
    tick(); chk_rec("ar.r1", 1'b1, 3'd1, 1'b0);
    chk("ar.count1", {16'd0, o_count}, 32'd1);
    #2 arst_n = 1'b0;
    #1;
    chk("ar.valid", {31'd0, o_valid}, 32'd0);
    chk("ar.count", {16'd0, o_count}, 32'd0);
    chk("ar.busy",  {31'd0, o_busy},  32'd0);
    tick(); tick();
    arst_n = 1'b1;
    begin
      int n = 0;
      while (!o_valid && n < 10) begin
        tick();
        n++;
      end
      chk("ar.reappear", {31'd0, o_valid}, 32'd1);
    end
    chk_rec("ar.q0", 1'b1, 3'd0, 1'b0);
    tick(); chk_rec("ar.q1", 1'b1, 3'd1, 1'b0);
    tick(); chk_rec("ar.q2", 1'b1, 3'd2, 1'b1);
    tick(); chk_rec("ar.qend", 1'b0, 3'd0, 1'b0);
    chk("ar.qcount", {16'd0, o_count}, 32'd3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
